// File: rtl/lock_key_loader.sv
// lock_key_loader: serial key-delivery front end for a logic-locked core.
//   Accepts a framed serial key stream over a valid/ready handshake. A frame is
//   KEY_W key bits (LSB first, first bit flagged by kin_start) followed by one
//   even-parity bit. A frame that passes the parity check is committed to the
//   held key register. A frame that fails leaves the committed key untouched.
//
// Parameters:
//   KEY_W     key bits per frame (>= 1)
//   MAX_FAIL  consecutive bad frames before lockout (LKL_LOCKOUT_EN builds only)
//
// Optional feature (macro LKL_LOCKOUT_EN):
//   When a failing frame brings fail_cnt up to MAX_FAIL, the loader enters a
//   LOCKOUT state. There it clears the key, holds kin_ready low and keeps
//   load_err set. Only rst_n leaves this state.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   kin_valid  serial bit valid
//   kin_ready  loader can accept a bit (IDLE/SHIFT)
//   kin_start  this bit is key bit 0 of a new frame
//   kin_bit    serial data
//   key_out    committed key, key_out[i] drives D_i
//   key_valid  key_out holds a parity-checked key
//   load_err   last completed frame failed parity (cleared by next start)
//   busy       frame in progress / checking / locked out
//   fail_cnt   consecutive bad frames, saturating at 3
module lock_key_loader #(
  parameter int unsigned KEY_W    = 2,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kin_valid,
  output logic             kin_ready,
  input  logic             kin_start,
  input  logic             kin_bit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             busy,
  output logic [1:0]       fail_cnt
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CHECK   = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   shadow_q;
  logic               par_q;
  logic [KEY_W-1:0]   key_q;
  logic               key_valid_q;
  logic               load_err_q;
  logic [1:0]         fail_q;

  logic               xfer;
  logic               at_parity;
  logic               parity_ok;
  logic [1:0]         fail_inc;
  logic               lock_hit;

  assign xfer      = kin_valid & kin_ready;
  assign at_parity = (cnt_q == CNT_W'(KEY_W));
  assign parity_ok = ~(^{shadow_q, par_q});
  assign fail_inc  = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

`ifdef LKL_LOCKOUT_EN
  assign lock_hit  = ({30'd0, fail_inc} >= 32'(MAX_FAIL));
`else
  assign lock_hit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    kin_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        kin_ready = 1'b1;
        busy      = 1'b0;
        if (xfer && kin_start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        kin_ready = 1'b1;
        // a start bit outranks the parity position and restarts the frame
        if (xfer && !kin_start && at_parity) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (!parity_ok && lock_hit) ? S_LOCKOUT : S_IDLE;
      end
`ifdef LKL_LOCKOUT_EN
      S_LOCKOUT: state_d = S_LOCKOUT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shadow_q    <= '0;
      par_q       <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      fail_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_SHIFT: begin
          if (xfer) begin
            if (kin_start) begin
              shadow_q   <= KEY_W'(kin_bit);
              cnt_q      <= CNT_W'(1);
              load_err_q <= 1'b0;
            end else if (state_q == S_SHIFT) begin
              if (at_parity) begin
                par_q <= kin_bit;
                cnt_q <= '0;
              end else begin
                for (int unsigned i = 1; i < KEY_W; i++) begin
                  if (cnt_q == CNT_W'(i)) shadow_q[i] <= kin_bit;
                end
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        S_CHECK: begin
          if (parity_ok) begin
            key_q       <= shadow_q;
            key_valid_q <= 1'b1;
            load_err_q  <= 1'b0;
            fail_q      <= '0;
          end else begin
            load_err_q <= 1'b1;
            fail_q     <= fail_inc;
            if (lock_hit) begin
              key_q       <= '0;
              key_valid_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign load_err  = load_err_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_lock_key_loader.sv
module tb_lock_key_loader;

  localparam int unsigned KEY_W    = 2;
  localparam int unsigned MAX_FAIL = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             kin_valid;
  logic             kin_ready;
  logic             kin_start;
  logic             kin_bit;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             load_err;
  logic             busy;
  logic [1:0]       fail_cnt;

  lock_key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kin_valid (kin_valid),
    .kin_ready (kin_ready),
    .kin_start (kin_start),
    .kin_bit   (kin_bit),
    .key_out   (key_out),
    .key_valid (key_valid),
    .load_err  (load_err),
    .busy      (busy),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KEY_W-1:0] key;
    logic             valid;
    logic             err;
    logic [1:0]       fail;
  } exp_t;

  exp_t sb[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model state
  logic [KEY_W-1:0] m_key;
  logic             m_valid;
  logic             m_err;
  int unsigned      m_fail;
  logic             m_locked;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_key = '0; m_valid = 1'b0; m_err = 1'b0; m_fail = 0; m_locked = 1'b0;
  endtask

  // frame outcome from the parity rule, pushed as the expected commit result
  task automatic model_frame(input logic [KEY_W-1:0] k, input logic p);
    exp_t e;
    if (($countones({k, p}) % 2) == 0) begin
      m_key = k; m_valid = 1'b1; m_err = 1'b0; m_fail = 0;
    end else begin
      m_err = 1'b1;
      m_fail = (m_fail < 3) ? m_fail + 1 : 3;
`ifdef LKL_LOCKOUT_EN
      if (m_fail >= MAX_FAIL) begin
        m_key = '0; m_valid = 1'b0; m_locked = 1'b1;
      end
`endif
    end
    e.key = m_key; e.valid = m_valid; e.err = m_err; e.fail = m_fail[1:0];
    sb.push_back(e);
  endtask

  // one handshake; entered and left at #1 after a rising edge
  task automatic xfer(input logic b, input logic s);
    int unsigned n = 0;
    logic r;
    kin_valid = 1'b1; kin_bit = b; kin_start = s;
    do begin
      r = kin_ready;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk("xfer_timeout", 32'(r), 32'd1);
    kin_valid = 1'b0; kin_start = 1'b0;
  endtask

  task automatic send_frame(input logic [KEY_W-1:0] k, input logic good);
    logic p;
    p = (^k) ^ ~good;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      xfer(k[i], i == 0);
      if (i == 0) begin
        m_err = 1'b0;
        chk("err_clr_on_start", 32'(load_err), 32'd0);
        chk("busy_in_frame", 32'(busy), 32'd1);
      end
    end
    xfer(p, 1'b0);
    model_frame(k, p);
  endtask

  task automatic do_reset();
    kin_valid = 1'b0; kin_start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    sb.delete();
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: fires on the first cycle after a CHECK cycle (busy & !ready)
  initial begin
    logic prev1, prev2, cur;
    exp_t e;
    prev1 = 1'b0; prev2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev1 = 1'b0; prev2 = 1'b0;
      end else begin
        cur = busy & ~kin_ready;
        if (prev1 && !prev2) begin
          if (sb.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("key_out", 32'(key_out), 32'(e.key));
            chk("key_valid", 32'(key_valid), 32'(e.valid));
            chk("load_err", 32'(load_err), 32'(e.err));
            chk("fail_cnt", 32'(fail_cnt), 32'(e.fail));
          end
        end
        prev2 = prev1;
        prev1 = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    kin_valid = 1'b0; kin_start = 1'b0; kin_bit = 1'b0; rst_n = 1'b0;
    model_clear();
    wait_cycles(2);
    do_reset();

    chk("rst_key", 32'(key_out), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(kin_ready), 32'd1);

    // good frame 0,1,parity 1; latency and valid held through CHECK
    send_frame(2'b10, 1'b1);
    chk("check_ready_low", 32'(kin_ready), 32'd0);
    chk("check_busy", 32'(busy), 32'd1);
    chk("key_before_commit", 32'(key_out), 32'd0);
    kin_valid = 1'b1; kin_start = 1'b0; kin_bit = 1'b1;
    wait_cycles(2);
    kin_valid = 1'b0;
    chk("key_after_commit", 32'(key_out), 32'h2);
    chk("idle_after_check", 32'(busy), 32'd0);

    // bad frame 1,1,parity 1
    send_frame(2'b11, 1'b0);
    wait_cycles(2);

    // dropped bit in IDLE, then restart mid-frame
    xfer(1'b1, 1'b0);
    chk("idle_drop_busy", 32'(busy), 32'd0);
    xfer(1'b1, 1'b1);
    send_frame(2'b10, 1'b1);
    wait_cycles(2);

    // reset mid-frame
    xfer(1'b1, 1'b1);
    do_reset();
    chk("midrst_key", 32'(key_out), 32'd0);
    chk("midrst_valid", 32'(key_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    send_frame(2'b01, 1'b1);
    wait_cycles(2);

    // three consecutive bad frames
    for (int i = 0; i < 3; i++) send_frame(2'(i), 1'b0);
    wait_cycles(3);
`ifdef LKL_LOCKOUT_EN
    chk("lockout_ready", 32'(kin_ready), 32'd0);
    chk("lockout_key", 32'(key_out), 32'd0);
    chk("lockout_err", 32'(load_err), 32'd1);
    do_reset();
`else
    chk("sat_fail_cnt", 32'(fail_cnt), 32'd3);
    send_frame(2'b00, 1'b0);
    send_frame(2'b11, 1'b1);
    wait_cycles(2);
    chk("fail_cleared", 32'(fail_cnt), 32'd0);
`endif

    // randomized frames
    for (int n = 0; n < 60; n++) begin
      if (m_locked) begin
        wait_cycles(3);
        chk("lock_ready", 32'(kin_ready), 32'd0);
        chk("lock_key", 32'(key_out), 32'd0);
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) xfer(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        xfer(1'($urandom_range(0, 1)), 1'b1);
        m_err = 1'b0;
        repeat ($urandom_range(0, KEY_W - 1)) xfer(1'($urandom_range(0, 1)), 1'b0);
      end
      send_frame(KEY_W'($urandom), $urandom_range(0, 9) > 2);
      wait_cycles($urandom_range(0, 2));
    end

    wait_cycles(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
